axi_lite_ram_slave: RTL and testbench

- AXI4-Lite responder that serves the core's memory bus (the slave end of the core's load/store master port).
- Backs a word-organised single-port RAM with byte-strobe writes.
- Read and write channels run independent FSMs and share the RAM port through a fixed-priority arbiter.
- Sits between the core's axi_* bus and on-chip memory, instantiated in the top-level SoC wrapper.

---
 rtl/axi_lite_pkg.sv | 23 ++
 rtl/bram_bytewe.sv | 40 ++++
 rtl/axi_lite_ram_slave.sv | 185 ++++++++++++++++++
 tb/tb_axi_lite_ram_slave.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI4-Lite RAM responder: response encodings and
// the state types of the independent read and write channel FSMs.
// -----------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_MEM,
        R_RESP
    } axi_r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } axi_w_state_t;

endpackage

// File: rtl/bram_bytewe.sv
// -----------------------------------------------------------------------------
// bram_bytewe
// Single-port word RAM, 32-bit words, one-cycle registered read, per-byte
// write enables. Read-first: a read and write in the same cycle return the
// old word. The output register only loads on a read so it holds its value
// across unrelated writes.
//
// Ports:
//   clk   in   clock
//   re_i  in   read enable (loads dout_o next edge)
//   we_i  in   4-bit byte write enable, bit i writes din_i[8i+7:8i]
//   addr_i in  word address
//   din_i in   write data
//   dout_o out read data, valid the cycle after re_i
// -----------------------------------------------------------------------------
module bram_bytewe #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  re_i,
    input  logic [3:0]            we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [31:0]           din_i,
    output logic [31:0]           dout_o
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem[addr_i][8*i +: 8] <= din_i[8*i +: 8];
            end
        end
        if (re_i) begin
            dout_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/axi_lite_ram_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_ram_slave
// AXI4-Lite responder backing a word-organised RAM with byte-strobe writes.
// Read and write channels have independent FSMs; they share the single RAM
// port, and a write in W_EXEC takes priority over a pending read.
//
// Optional build macro: AXI_SLAVE_RANGE_CHECK_EN
//   defined   - accesses outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2)
//               return SLVERR, reads give zero data, RAM is not touched.
//   undefined - addresses wrap modulo the window size, always OKAY.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   axi_ar*                  read address channel (byte address)
//   axi_r*                   read data channel
//   axi_aw*                  write address channel (byte address)
//   axi_w*                   write data channel with byte strobes
//   axi_b*                   write response channel
// -----------------------------------------------------------------------------
module axi_lite_ram_slave #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready
);
    import axi_lite_pkg::*;

    axi_r_state_t r_state_q, r_state_d;
    axi_w_state_t w_state_q, w_state_d;
    logic         aw_got_q, aw_got_d;
    logic         w_got_q, w_got_d;
    logic [31:0]  ar_addr_q, aw_addr_q, wdata_q;
    logic [3:0]   wstrb_q;

    logic ar_hs, aw_hs, w_hs;
    logic [31:0] r_off, w_off;
    logic rd_oor, wr_oor;
    logic ram_re;
    logic [3:0] ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [31:0] ram_dout;

    assign ar_hs = axi_arvalid && axi_arready;
    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;

    // Offsets from the window base; the word index drops the byte-lane bits.
    assign r_off = ar_addr_q - BASE_ADDR;
    assign w_off = aw_addr_q - BASE_ADDR;

`ifdef AXI_SLAVE_RANGE_CHECK_EN
    // 33 bits so a window ending at 4 GiB does not overflow.
    localparam logic [32:0] WIN_BYTES = 33'd1 << (DEPTH_LOG2 + 2);
    assign rd_oor = (ar_addr_q < BASE_ADDR) || ({1'b0, r_off} >= WIN_BYTES);
    assign wr_oor = (aw_addr_q < BASE_ADDR) || ({1'b0, w_off} >= WIN_BYTES);
`else
    assign rd_oor = 1'b0;
    assign wr_oor = 1'b0;
`endif

    // Offset bits above the window and the byte-lane bits carry no index info.
    logic unused_off_bits;
    assign unused_off_bits = ^{r_off[31:DEPTH_LOG2+2], r_off[1:0],
                               w_off[31:DEPTH_LOG2+2], w_off[1:0]};

    // Fixed-priority port arbiter: write execution wins, read waits in R_MEM.
    always_comb begin
        ram_re   = 1'b0;
        ram_we   = 4'b0000;
        ram_addr = r_off[DEPTH_LOG2+1:2];
        if (w_state_q == W_EXEC) begin
            ram_addr = w_off[DEPTH_LOG2+1:2];
            if (!wr_oor) begin
                ram_we = wstrb_q;
            end
        end else if (r_state_q == R_MEM && !rd_oor) begin
            ram_re = 1'b1;
        end
    end

    bram_bytewe #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .re_i  (ram_re),
        .we_i  (ram_we),
        .addr_i(ram_addr),
        .din_i (wdata_q),
        .dout_o(ram_dout)
    );

    // Read channel
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE: if (ar_hs) r_state_d = R_MEM;
            R_MEM:  if (w_state_q != W_EXEC) r_state_d = R_RESP;
            R_RESP: if (axi_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
        if (ar_hs) begin
            ar_addr_q <= axi_araddr;
        end
    end

    assign axi_arready = (r_state_q == R_IDLE);
    assign axi_rvalid  = (r_state_q == R_RESP);
    // RAM output register holds between reads, so rdata is stable under stall.
    assign axi_rdata   = (axi_rvalid && !rd_oor) ? ram_dout : 32'h0;
    assign axi_rresp   = (axi_rvalid && rd_oor) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    // Write channel: AW and W captured independently, executed once both held.
    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) aw_got_d = 1'b1;
                if (w_hs)  w_got_d  = 1'b1;
                if (aw_got_d && w_got_d) w_state_d = W_EXEC;
            end
            W_EXEC: w_state_d = W_RESP;
            W_RESP: begin
                if (axi_bready) begin
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
        end
        if (aw_hs) begin
            aw_addr_q <= axi_awaddr;
        end
        if (w_hs) begin
            wdata_q <= axi_wdata;
            wstrb_q <= axi_wstrb;
        end
    end

    assign axi_awready = (w_state_q == W_IDLE) && !aw_got_q;
    assign axi_wready  = (w_state_q == W_IDLE) && !w_got_q;
    assign axi_bvalid  = (w_state_q == W_RESP);
    assign axi_bresp   = (axi_bvalid && wr_oor) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
module tb_axi_lite_ram_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t      rexp_q[$];
    logic [1:0] bexp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_lite_ram_slave #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
        .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no event, want one within 20 cycles", name);
    endtask

    // Scoreboard monitor: pops an expectation on every response handshake.
    always @(negedge clk) begin : mon
        rexp_t      e;
        logic [1:0] eb;
        if (!rst && rvalid && rready) begin
            if (rexp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL r_unexpected: got rdata %h, want no response", rdata);
            end else begin
                e = rexp_q.pop_front();
                chk("r_data", rdata, e.data);
                chk("r_resp", {30'b0, rresp}, {30'b0, e.resp});
            end
        end
        if (!rst && bvalid && bready) begin
            if (bexp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got bresp %h, want no response", bresp);
            end else begin
                eb = bexp_q.pop_front();
                chk("b_resp", {30'b0, bresp}, {30'b0, eb});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1.
    task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                           input int bp, input int exp_lat, input string tag);
        rexp_t       e;
        int          hs = -1;
        bit          h, got = 0;
        logic [31:0] held;
        e.data = ed; e.resp = er;
        rexp_q.push_back(e);
        rready  = (bp == 0);
        araddr  = a;
        arvalid = 1'b1;
        for (int k = 0; k < 20 && hs < 0; k++) begin
            @(negedge clk); h = arready;
            @(posedge clk); #1;
            if (h) begin hs = cyc; arvalid = 1'b0; end
        end
        if (hs < 0) begin arvalid = 1'b0; timeout({tag, "_ar"}); return; end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rvalid) begin
                got = 1;
                chk({tag, "_rlat"}, 32'(cyc - hs), 32'(exp_lat));
            end
        end
        if (!got) begin rready = 1'b1; timeout({tag, "_r"}); return; end
        held = rdata;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            chk({tag, "_rvalid_hold"}, {31'b0, rvalid}, 32'd1);
            chk({tag, "_rdata_hold"}, rdata, held);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        for (int k = 0; k < 5 && rvalid; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input logic [1:0] er,
                            input int bp, input string tag);
        bit          aw_done = 0, w_done = 0, ah, wh, got = 0;
        int          hs = -1;
        logic [1:0]  held;
        bexp_q.push_back(er);
        bready = (bp == 0);
        for (int k = 0; k < 20 && hs < 0; k++) begin
            if (!aw_done && k >= awd) begin awaddr = a; awvalid = 1'b1; end
            if (!w_done && k >= wd) begin wdata = d; wstrb = s; wvalid = 1'b1; end
            @(negedge clk);
            ah = awvalid && awready;
            wh = wvalid && wready;
            if (aw_done && !w_done) begin
                chk({tag, "_awready_low"}, {31'b0, awready}, 32'd0);
                chk({tag, "_no_early_b"}, {31'b0, bvalid}, 32'd0);
            end
            if (w_done && !aw_done) begin
                chk({tag, "_wready_low"}, {31'b0, wready}, 32'd0);
                chk({tag, "_no_early_b"}, {31'b0, bvalid}, 32'd0);
            end
            @(posedge clk); #1;
            if (ah) begin aw_done = 1; awvalid = 1'b0; end
            if (wh) begin w_done = 1; wvalid = 1'b0; end
            if (aw_done && w_done) hs = cyc;
        end
        if (hs < 0) begin awvalid = 1'b0; wvalid = 1'b0; timeout({tag, "_aw_w"}); return; end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bvalid) begin
                got = 1;
                chk({tag, "_blat"}, 32'(cyc - hs), 32'd1);
            end
        end
        if (!got) begin bready = 1'b1; timeout({tag, "_b"}); return; end
        held = bresp;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            chk({tag, "_bvalid_hold"}, {31'b0, bvalid}, 32'd1);
            chk({tag, "_bresp_hold"}, {30'b0, bresp}, {30'b0, held});
        end
        @(posedge clk); #1;
        bready = 1'b1;
        for (int k = 0; k < 5 && bvalid; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, "_single_b"}, {31'b0, bvalid}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000 time units");
        $fatal(1);
    end

    initial begin
        bit got;
        rst = 1'b1;
        arvalid = 0; awvalid = 0; wvalid = 0; rready = 1; bready = 1;
        araddr = 0; awaddr = 0; wdata = 0; wstrb = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", {31'b0, arready}, 32'd1);
        chk("rst_awready", {31'b0, awready}, 32'd1);
        chk("rst_wready",  {31'b0, wready},  32'd1);
        chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
        chk("rst_bvalid",  {31'b0, bvalid},  32'd0);
        chk("rst_rdata",   rdata, 32'h0);
        chk("rst_rresp",   {30'b0, rresp}, 32'd0);
        chk("rst_bresp",   {30'b0, bresp}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, OKAY, 0, "wr_same");
        do_read (32'h10, 32'hDEADBEEF, OKAY, 0, 1, "rd_same");
        do_write(32'h10, 32'h00AB0000, 4'b0100, 0, 0, OKAY, 0, "wr_strb");
        do_read (32'h10, 32'hDEABBEEF, OKAY, 0, 1, "rd_strb");
        do_write(32'h10, 32'hFFFFFFFF, 4'b0000, 0, 0, OKAY, 0, "wr_nostrb");
        do_read (32'h13, 32'hDEABBEEF, OKAY, 0, 1, "rd_lane");

        do_write(32'h14, 32'hA5A50001, 4'hF, 0, 3, OKAY, 0, "wr_awfirst");
        do_read (32'h14, 32'hA5A50001, OKAY, 0, 1, "rd_awfirst");
        do_write(32'h18, 32'h5A5A0002, 4'hF, 3, 0, OKAY, 0, "wr_wfirst");
        do_read (32'h18, 32'h5A5A0002, OKAY, 0, 1, "rd_wfirst");

        do_read (32'h14, 32'hA5A50001, OKAY, 5, 1, "rd_bp");
        do_write(32'h1C, 32'h0BADCAFE, 4'hF, 0, 0, OKAY, 5, "wr_bp");
        do_read (32'h1C, 32'h0BADCAFE, OKAY, 0, 1, "rd_bpw");

        // Read and write handshake together: write executes first, read stalls.
        fork
            do_write(32'h20, 32'h12345678, 4'hF, 0, 0, OKAY, 0, "col_w");
            do_read (32'h20, 32'h12345678, OKAY, 0, 2, "col_r");
        join

        // Reset while the write response is pending.
        bready = 1'b0;
        awaddr = 32'h30; wdata = 32'h30303030; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = bvalid;
        end
        chk("rstw_bvalid_before", {31'b0, got}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_bvalid",  {31'b0, bvalid},  32'd0);
        chk("rstw_arready", {31'b0, arready}, 32'd1);
        chk("rstw_awready", {31'b0, awready}, 32'd1);
        chk("rstw_wready",  {31'b0, wready},  32'd1);
        chk("rstw_bresp",   {30'b0, bresp},   32'd0);
        @(posedge clk); #1;
        bready = 1'b1;
        do_read (32'h30, 32'h30303030, OKAY, 0, 1, "rd_after_rst");
        do_read (32'h10, 32'hDEABBEEF, OKAY, 0, 1, "rd_kept");

        do_write(32'h0, 32'h11223344, 4'hF, 0, 0, OKAY, 0, "wr_word0");
`ifdef AXI_SLAVE_RANGE_CHECK_EN
        do_read (32'h4000, 32'h0, SLVERR, 0, 1, "rd_oor");
        do_write(32'h4000, 32'hCAFEF00D, 4'hF, 0, 0, SLVERR, 0, "wr_oor");
        do_read (32'h0, 32'h11223344, OKAY, 0, 1, "rd_word0");
`else
        do_write(32'h4000, 32'hCAFEF00D, 4'hF, 0, 0, OKAY, 0, "wr_wrap");
        do_read (32'h0, 32'hCAFEF00D, OKAY, 0, 1, "rd_word0");
        do_read (32'h4000, 32'hCAFEF00D, OKAY, 0, 1, "rd_wrap");
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("r_queue_empty", 32'(rexp_q.size()), 32'd0);
        chk("b_queue_empty", 32'(bexp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
